// File: rtl/fn_sweep_ctrl.sv
// Self-test sequencer for a 4-input combinational unit: sweeps {a,b,c,d} = 0..15,
// samples f_in after SETTLE cycles per vector, and scores the captured table against EXPECTED.
module fn_sweep_ctrl #(
  parameter logic [2:0]  SETTLE   = 3'd1,
  parameter logic [15:0] EXPECTED = 16'hF830
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_bad,
  output logic [15:0] table_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] SETTLE_LAST = SETTLE - 3'd1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [2:0]  settle_q, settle_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  err_q, err_d;
  logic [3:0]  first_bad_q, first_bad_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  abcd_q, abcd_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned (no latch).
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    table_d     = table_q;
    err_d       = err_q;
    first_bad_d = first_bad_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          vec_d       = 4'd0;
          settle_d    = 3'd0;
          table_d     = 16'd0;
          err_d       = 5'd0;
          first_bad_d = 4'd0;
          pass_d      = 1'b0;
        end
      end
      S_RUN: begin
        // Abort takes priority over the sample that would otherwise land on this edge.
        if (abort) begin
          state_d  = S_IDLE;
          vec_d    = 4'd0;
          settle_d = 3'd0;
        end else if (settle_q == SETTLE_LAST) begin
          table_d[vec_q] = f_in;
          if (f_in != EXPECTED[vec_q]) begin
            err_d = err_q + 5'd1;
            if (err_q == 5'd0) first_bad_d = vec_q;
          end
          settle_d = 3'd0;
          vec_d    = vec_q + 4'd1;
          if (vec_q == 4'd15) begin
            state_d = S_DONE;
            pass_d  = (err_d == 5'd0);
          end
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    abcd_d = busy_d ? vec_d : 4'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= S_IDLE;
      vec_q       <= 4'd0;
      settle_q    <= 3'd0;
      table_q     <= 16'd0;
      err_q       <= 5'd0;
      first_bad_q <= 4'd0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abcd_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      table_q     <= table_d;
      err_q       <= err_d;
      first_bad_q <= first_bad_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abcd_q      <= abcd_d;
    end
  end

  assign {a, b, c, d} = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_q;
  assign first_bad    = first_bad_q;
  assign table_out    = table_q;

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// Directed bench for fn_sweep_ctrl: one instance with SETTLE=1 and a selectable fault model,
// one with SETTLE=3 fed by a golden unit behind two register stages.
module tb_fn_sweep_ctrl;

  logic clk;
  logic reset;
  logic start1, abort1, start3, abort3;
  logic [1:0] mode;
  logic sel;

  logic a1, b1, c1, d1, busy1, done1, pass1, f1;
  logic [4:0] err1;
  logic [3:0] fb1;
  logic [15:0] tab1;

  logic a3, b3, c3, d3, busy3, done3, pass3, f3;
  logic [4:0] err3;
  logic [3:0] fb3;
  logic [15:0] tab3;

  logic [3:0] vec1, vec3;
  logic [3:0] st1 = 4'd0;
  logic [3:0] st2 = 4'd0;

  int checks   = 0;
  int failures = 0;

  function automatic logic golden(input logic [3:0] v);
    logic ga, gb, gc, gd;
    {ga, gb, gc, gd} = v;
    return (ga & ((gc & gd) | gb)) | (gb & ~gc);
  endfunction

  assign vec1 = {a1, b1, c1, d1};
  assign vec3 = {a3, b3, c3, d3};

  // mode 0: golden, 1: stuck at 0, 2: golden with vectors 2 and 13 inverted
  assign f1 = (mode == 2'd1) ? 1'b0
            : (golden(vec1) ^ ((mode == 2'd2) && (vec1 == 4'd2 || vec1 == 4'd13)));

  always @(posedge clk) begin
    st1 <= vec3;
    st2 <= st1;
  end
  assign f3 = golden(st2);

  fn_sweep_ctrl #(.SETTLE(3'd1), .EXPECTED(16'hF830)) dut (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_bad(fb1), .table_out(tab1)
  );

  fn_sweep_ctrl #(.SETTLE(3'd3), .EXPECTED(16'hF830)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .f_in(f3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_bad(fb3), .table_out(tab3)
  );

  logic        m_busy, m_done, m_pass;
  logic [3:0]  m_vec;
  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_pass = sel ? pass3 : pass1;
  assign m_vec  = sel ? vec3  : vec1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start3 = v;
    else     start1 = v;
  endtask

  // Pulses start for one edge, then follows the sweep to its done pulse, checking timing and vectors.
  task automatic do_sweep(input int settle, input string tag);
    int n, busy_n, vec_err;
    n = 0; busy_n = 0; vec_err = 0;
    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    while (m_done !== 1'b1 && n < 200) begin
      if (m_busy === 1'b1) busy_n++;
      if (m_vec !== 4'(n / settle)) vec_err++;
      tick();
      n++;
    end
    check({tag, "_done_edges"}, n, 16 * settle);
    check({tag, "_busy_cycles"}, busy_n, 16 * settle);
    check({tag, "_vec_seq_errs"}, vec_err, 0);
    check({tag, "_busy_at_done"}, m_busy, 0);
    tick();
    check({tag, "_done_one_cycle"}, m_done, 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (m_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, m_done, 1);
  endtask

  initial begin
    int done_cnt, idle_cnt, busy_cnt;
    reset = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode = 2'd0; sel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_pass",  pass1, 0);
    check("rst_err",   err1, 0);
    check("rst_fb",    fb1, 0);
    check("rst_table", tab1, 16'h0000);
    check("rst_vec",   vec1, 0);

    // Golden unit, SETTLE=1
    do_sweep(1, "t1");
    check("t1_table", tab1, 16'hF830);
    check("t1_pass",  pass1, 1);
    check("t1_err",   err1, 0);
    check("t1_fb",    fb1, 0);
    repeat (3) tick();
    check("t1_hold_table", tab1, 16'hF830);
    check("t1_hold_pass",  pass1, 1);

    // Stuck-at-0 unit
    mode = 2'd1;
    do_sweep(1, "t2");
    check("t2_table", tab1, 16'h0000);
    check("t2_err",   err1, 7);
    check("t2_fb",    fb1, 4);
    check("t2_pass",  pass1, 0);

    // Two inverted vectors
    mode = 2'd2;
    do_sweep(1, "t2b");
    check("t2b_table", tab1, 16'hD834);
    check("t2b_err",   err1, 2);
    check("t2b_fb",    fb1, 2);
    check("t2b_pass",  pass1, 0);
    mode = 2'd0;

    // SETTLE=3 behind two register stages
    sel = 1'b1;
    do_sweep(3, "t3");
    check("t3_table", tab3, 16'hF830);
    check("t3_pass",  pass3, 1);
    check("t3_err",   err3, 0);
    sel = 1'b0;

    // Abort at vec=6
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (6) tick();
    check("t4_vec_before_abort", vec1, 6);
    abort1 = 1'b1; tick(); abort1 = 1'b0;
    check("t4_busy", busy1, 0);
    check("t4_vec",  vec1, 0);
    check("t4_pass", pass1, 0);
    check("t4_partial_table", tab1, 16'h0030);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done1 === 1'b1) done_cnt++;
      tick();
    end
    check("t4_no_done", done_cnt, 0);
    do_sweep(1, "t4r");
    check("t4r_pass",  pass1, 1);
    check("t4r_table", tab1, 16'hF830);

    // start held high for 40 cycles
    start1 = 1'b1;
    done_cnt = 0; idle_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1 === 1'b1) done_cnt++;
      if (busy1 === 1'b0 && done1 === 1'b0) idle_cnt++;
      if (busy1 === 1'b1) busy_cnt++;
    end
    start1 = 1'b0;
    check("t5_done_pulses", done_cnt, 2);
    check("t5_idle_gaps",   idle_cnt, 2);
    check("t5_busy_cycles", busy_cnt, 36);
    check("t5_third_vec",   vec1, 3);
    wait_done("t5_third_done");
    check("t5_pass", pass1, 1);
    tick();

    // start pulse mid-sweep must not restart the sequence
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (5) tick();
    check("t5b_vec5", vec1, 5);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("t5b_vec6", vec1, 6);
    wait_done("t5b_done");
    check("t5b_pass", pass1, 1);
    tick();

    // Reset mid-sweep at vec=9, with start also high on the reset edge
    mode = 2'd1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (9) tick();
    check("t6_vec9", vec1, 9);
    check("t6_err_pre", err1, 2);
    reset = 1'b1; start1 = 1'b1;
    tick();
    check("t6_busy",  busy1, 0);
    check("t6_done",  done1, 0);
    check("t6_vec",   vec1, 0);
    check("t6_table", tab1, 16'h0000);
    check("t6_err",   err1, 0);
    check("t6_fb",    fb1, 0);
    check("t6_pass",  pass1, 0);
    reset = 1'b0; start1 = 1'b0; mode = 2'd0;
    tick();
    check("t6_idle_after", busy1, 0);
    do_sweep(1, "t6r");
    check("t6r_pass",  pass1, 1);
    check("t6r_table", tab1, 16'hF830);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
